// File: rtl/l2norm_pkg.sv
// Shared constants and state encoding for the L2-norm square-root stage.
package l2norm_pkg;

  localparam int IN_W  = 20;
  localparam int OUT_W = IN_W / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

endpackage

// File: rtl/sqrt_step.sv
// One digit-recurrence iteration of the integer square root (purely combinational).
module sqrt_step #(
  parameter int OUT_W = 10
) (
  input  logic [OUT_W:0]   rem,
  input  logic [OUT_W-1:0] root,
  input  logic [1:0]       pair,
  output logic [OUT_W:0]   rem_nxt,
  output logic [OUT_W-1:0] root_nxt
);

  logic ge;
  logic [OUT_W:0] r_lo;
  logic [OUT_W:0] t_lo;

  // Full-width compare; the difference only needs the low OUT_W+1 bits
  // because a non-negative result always fits in the remainder register.
  assign ge   = ({rem, pair} >= {1'b0, root, 2'b01});
  assign r_lo = {rem[OUT_W-2:0], pair};
  assign t_lo = {root[OUT_W-2:0], 2'b01};

  assign rem_nxt  = ge ? (r_lo - t_lo) : r_lo;
  assign root_nxt = {root[OUT_W-2:0], ge};

endmodule

// File: rtl/l2_norm_sqrt.sv
// Integer square root of the sum-of-squares, one root bit per cycle, valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for an operand; sos_ready=1
// CALC  | one iteration per clock, MSB pair first
// DONE  | root/rem held, res_valid=1 until res_ready
module l2_norm_sqrt
  import l2norm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    sos,
  input  logic               sos_valid,
  output logic               sos_ready,
  output logic [OUT_W-1:0]   root,
  output logic [OUT_W:0]     rem,
  output logic               res_valid,
  input  logic               res_ready
);

  localparam int CNT_W = $clog2(OUT_W);

  sqrt_state_t state, state_nxt;
  logic [IN_W-1:0]  opnd;
  logic [OUT_W-1:0] root_q, root_nxt;
  logic [OUT_W:0]   rem_q, rem_nxt;
  logic [CNT_W-1:0] cnt;

  sqrt_step #(.OUT_W(OUT_W)) u_step (
    .rem      (rem_q),
    .root     (root_q),
    .pair     (opnd[IN_W-1:IN_W-2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sos_valid) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opnd   <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (sos_valid) begin
          opnd   <= sos;
          root_q <= '0;
          rem_q  <= '0;
          cnt    <= CNT_W'(OUT_W - 1);
        end
        CALC: begin
          opnd   <= {opnd[IN_W-3:0], 2'b00};
          root_q <= root_nxt;
          rem_q  <= rem_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sos_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign root      = root_q;
  assign rem       = rem_q;

endmodule

// File: tb/tb_l2_norm_sqrt.sv
// Directed and random checks of the square-root stage against hand values and a floor-sqrt model.
module tb_l2_norm_sqrt;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] sos = '0;
  logic        sos_valid = 1'b0;
  logic        sos_ready;
  logic [9:0]  root;
  logic [10:0] rem;
  logic        res_valid;
  logic        res_ready = 1'b0;

  int nchecks = 0;
  int nerr = 0;

  l2_norm_sqrt dut (
    .clk       (clk),
    .reset     (reset),
    .sos       (sos),
    .sos_valid (sos_valid),
    .sos_ready (sos_ready),
    .root      (root),
    .rem       (rem),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, check latency and result; optionally release it.
  task automatic run_op(input string tag, input int v, input int exp_root,
                        input int exp_rem, input bit do_release);
    int n = 0;
    while (!sos_ready && n < 50) begin cyc(); n++; end
    chk({tag, " ready"}, {31'd0, sos_ready}, 32'd1);
    sos = 20'(v);
    sos_valid = 1'b1;
    cyc();
    sos_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin cyc(); n++; end
    chk({tag, " latency"}, n, 32'd10);
    chk({tag, " root"}, {22'd0, root}, exp_root);
    chk({tag, " rem"}, {21'd0, rem}, exp_rem);
    if (do_release) begin
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      chk({tag, " valid drop"}, {31'd0, res_valid}, 32'd0);
      chk({tag, " ready back"}, {31'd0, sos_ready}, 32'd1);
    end
  endtask

  initial begin
    int n;
    int v;
    int m;

    #12;
    chk("reset res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset sos_ready", {31'd0, sos_ready}, 32'd1);
    chk("reset root", {22'd0, root}, 32'd0);
    chk("reset rem", {21'd0, rem}, 32'd0);
    #5 reset = 1'b1;
    cyc();

    run_op("zero", 0, 0, 0, 1'b1);
    run_op("million", 1000000, 1000, 0, 1'b1);
    run_op("ninety-nine", 99, 9, 18, 1'b1);
    run_op("all-ones", 1048575, 1023, 2046, 1'b1);

    // Backpressure: hold result 5 cycles, stray operand must be ignored.
    run_op("bp", 99, 9, 18, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin sos = 20'd400; sos_valid = 1'b1; end
      cyc();
      sos_valid = 1'b0;
      chk("bp hold valid", {31'd0, res_valid}, 32'd1);
      chk("bp hold ready", {31'd0, sos_ready}, 32'd0);
      chk("bp hold root", {22'd0, root}, 32'd9);
      chk("bp hold rem", {21'd0, rem}, 32'd18);
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("bp release idle", {31'd0, sos_ready}, 32'd1);
    run_op("four-hundred", 400, 20, 0, 1'b1);

    // Reset in the middle of the computation.
    sos = 20'd1000000;
    sos_valid = 1'b1;
    cyc();
    sos_valid = 1'b0;
    repeat (4) cyc();
    chk("mid calc busy", {31'd0, sos_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst valid", {31'd0, res_valid}, 32'd0);
    chk("midrst root", {22'd0, root}, 32'd0);
    chk("midrst rem", {21'd0, rem}, 32'd0);
    #3 reset = 1'b1;
    cyc();
    chk("midrst ready", {31'd0, sos_ready}, 32'd1);
    run_op("one-forty-four", 144, 12, 0, 1'b1);

    // Random stream with random downstream backpressure.
    for (int i = 0; i < 50; i++) begin
      v = int'($urandom_range(0, 1048575));
      m = isqrt(v);
      sos = 20'(v);
      sos_valid = 1'b1;
      n = 0;
      while (!sos_ready && n < 100) begin
        res_ready = 1'($urandom % 2);
        cyc();
        n++;
      end
      cyc();
      sos_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 40) begin cyc(); n++; end
      chk("rnd arrive", {31'd0, res_valid}, 32'd1);
      chk("rnd root", {22'd0, root}, m);
      chk("rnd identity", int'(root) * int'(root) + int'(rem), v);
      chk("rnd rem bound", {31'd0, (int'(rem) <= 2 * int'(root))}, 32'd1);
      n = 0;
      res_ready = 1'($urandom % 2);
      while (!(res_valid && res_ready) && n < 100) begin
        cyc();
        res_ready = 1'($urandom % 2);
        n++;
      end
      if (res_valid && res_ready) begin
        cyc();
        chk("rnd handoff", {31'd0, res_valid}, 32'd0);
      end else begin
        chk("rnd handoff timeout", {31'd0, res_ready}, 32'd1);
      end
      res_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
